// File: rtl/uart_tx.sv
// ==== uart_tx: serializes start / DATA_WIDTH bits LSB first / even parity / stop ====
// ==== rev 1.0 : initial release                                                 ====
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  txd_o,
  output logic                  tx_done_o
);

  localparam int CYCLES_PER_TICK = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BIT_CYCLES      = CYCLES_PER_TICK * 16;
  localparam int CNT_W           = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W           = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (CYCLES_PER_TICK < 1) begin : g_bad_divisor
    $error("uart_tx: CLK_FREQ too low for BAUD_RATE (CYCLES_PER_TICK < 1)");
  end

  if ((DATA_WIDTH < 1) || (DATA_WIDTH > 16)) begin : g_bad_width
    $error("uart_tx: DATA_WIDTH must be in 1..16");
  end

  logic [2:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic                  parity_q, parity_d;
  logic                  txd_q,    txd_d;
  logic                  done_q,   done_d;
  logic                  bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_valid_i) begin
          shift_d  = tx_data_i;
          parity_d = ^tx_data_i;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so TxD is registered yet aligned to the bit edge
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = parity_d;
      default:  txd_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready_o = (state_q == S_IDLE);
  assign txd_o      = txd_q;
  assign tx_done_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ==== tb_uart_tx: directed frame checks for uart_tx with a sampling receiver model ====
// ==== rev 1.0 : initial release                                                     ====
`default_nettype none

module tb_uart_tx;

  localparam int BIT   = 16;
  localparam int FRAME = 11 * BIT;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       txd;
  logic       tx_done;

  int n_pass   = 0;
  int n_total  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int base;

  uart_tx #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .DATA_WIDTH(8)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .tx_valid_i(tx_valid),
    .tx_data_i (tx_data),
    .tx_ready_o(tx_ready),
    .txd_o     (txd),
    .tx_done_o (tx_done)
  );

  always #5 clk = ~clk;

  // Completion pulses, sampled well after the edge that produces them
  always @(posedge clk) begin
    #2;
    if (tx_done === 1'b1) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
  endtask

  // Walks one frame cycle by cycle from the negedge after acceptance; par is hand-computed
  task automatic watch_frame(input string name, input logic [7:0] d, input logic par, input bit hold);
    logic [10:0] bits;
    logic [7:0]  rx;
    logic        rx_start, rx_par, rx_stop;
    int          k;
    bits     = {1'b1, par, d, 1'b0};
    rx       = 8'h00;
    rx_start = 1'b1;
    rx_par   = 1'b0;
    rx_stop  = 1'b0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      if (j == 1 && !hold) tx_valid = 1'b0;
      if (j == 40) tx_data = 8'hFF;
      k = (j - 1) / BIT;
      check($sformatf("%s_txd_c%0d", name, j), {31'd0, txd}, {31'd0, bits[k]});
      check($sformatf("%s_ready_c%0d", name, j), {31'd0, tx_ready}, 32'd0);
      check($sformatf("%s_done_c%0d", name, j), {31'd0, tx_done}, 32'd0);
      if ((j - 1) % BIT == BIT / 2) begin
        if (k == 0)       rx_start  = txd;
        else if (k <= 8)  rx[k-1]   = txd;
        else if (k == 9)  rx_par    = txd;
        else              rx_stop   = txd;
      end
    end
    @(negedge clk);
    check($sformatf("%s_done_end", name), {31'd0, tx_done}, 32'd1);
    check($sformatf("%s_ready_end", name), {31'd0, tx_ready}, 32'd1);
    check($sformatf("%s_txd_end", name), {31'd0, txd}, 32'd1);
    check($sformatf("%s_rxdata", name), {24'd0, rx}, {24'd0, d});
    check($sformatf("%s_valid_rx", name),
          {31'd0, (!rx_start && rx_stop && ((^{rx, rx_par}) == 1'b0))}, 32'd1);
  endtask

  task automatic idle_after(input string name, input int pulses);
    @(negedge clk);
    check($sformatf("%s_done_low", name), {31'd0, tx_done}, 32'd0);
    check($sformatf("%s_idle_ready", name), {31'd0, tx_ready}, 32'd1);
    check($sformatf("%s_idle_txd", name), {31'd0, txd}, 32'd1);
    check($sformatf("%s_pulses", name), done_cnt - base, pulses);
  endtask

  initial begin
    // Reset applied before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_txd", {31'd0, txd}, 32'd1);
    check("idle_ready", {31'd0, tx_ready}, 32'd1);

    base = done_cnt;
    start_frame(8'hA5);
    watch_frame("a5", 8'hA5, 1'b0, 1'b0);
    idle_after("a5", 1);

    base = done_cnt;
    start_frame(8'h07);
    watch_frame("x07", 8'h07, 1'b1, 1'b0);
    idle_after("x07", 1);

    base = done_cnt;
    start_frame(8'h00);
    watch_frame("x00", 8'h00, 1'b0, 1'b0);
    idle_after("x00", 1);

    // Valid held high: tx_data goes to 0xFF mid-frame and is taken at E+177
    base = done_cnt;
    start_frame(8'h3C);
    watch_frame("busy3c", 8'h3C, 1'b0, 1'b1);
    watch_frame("busyff", 8'hFF, 1'b0, 1'b0);
    idle_after("busy", 2);

    // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the line visibly jumps high)
    base = done_cnt;
    start_frame(8'hC3);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (69) @(negedge clk);
    check("c3_bit3_before_rst", {31'd0, txd}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midrst_txd", {31'd0, txd}, 32'd1);
    check("midrst_ready", {31'd0, tx_ready}, 32'd1);
    check("midrst_done", {31'd0, tx_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_hold_txd", {31'd0, txd}, 32'd1);
    reset = 1'b0;
    check("midrst_pulses", done_cnt - base, 0);

    base = done_cnt;
    start_frame(8'h5A);
    watch_frame("x5a", 8'h5A, 1'b0, 1'b0);
    idle_after("x5a", 1);

    // Loopback words
    base = done_cnt;
    start_frame(8'h3C);
    watch_frame("lb3c", 8'h3C, 1'b0, 1'b0);
    start_frame(8'hFF);
    watch_frame("lbff", 8'hFF, 1'b0, 1'b0);
    start_frame(8'h01);
    watch_frame("lb01", 8'h01, 1'b1, 1'b0);
    idle_after("lb", 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
